// File: rtl/dr_cache_initiator_pkg.sv
// Shared definitions for the dual-rail cache initiator: FSM state codes, spacer
// constants and the dual-rail encode/decode helpers.
package dr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_W_REQ = 3'd1;
  localparam state_t ST_W_RTZ = 3'd2;
  localparam state_t ST_R_REQ = 3'd3;
  localparam state_t ST_R_CAP = 3'd4;
  localparam state_t ST_R_ACK = 3'd5;

  localparam logic [3:0]  DR_NULL_ADDR = 4'b0000;
  localparam logic [15:0] DR_NULL_DATA = 16'h0000;
  localparam logic [1:0]  DR_NULL_CMD  = 2'b00;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } dr_dec_t;

  // Bit b becomes the pair {true, false} = {b, ~b}.
  function automatic logic [15:0] dr_encode(input logic [7:0] value);
    logic [15:0] rails;
    rails = '0;
    for (int i = 0; i < 8; i++) begin
      rails[2*i+1] = value[i];
      rails[2*i]   = ~value[i];
    end
    return rails;
  endfunction

  // A pair is a legal codeword only when exactly one rail is high; bad pairs
  // decode to 0 and clear the overall valid flag.
  function automatic dr_dec_t dr_decode(input logic [15:0] rails);
    dr_dec_t res;
    res.data  = '0;
    res.valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rails[2*i+1] ^ rails[2*i]) begin
        res.data[i] = rails[2*i+1];
      end else begin
        res.valid = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dr_cache_initiator_if.sv
// Synchronous request/response bus between the requesting logic (master)
// and the dual-rail cache initiator (slave).
interface dr_cache_initiator_if;
  import dr_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dr_cache_initiator_sync_ff.sv
// Plain flop-chain synchroniser for a single asynchronous level signal.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dr_cache_initiator.sv
// Clocked requesting end of the dual-rail four-phase RTZ cache port: encodes
// single-word requests onto the rails and decodes/validates returned read data.
module dr_cache_initiator
  import dr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dr_cache_initiator_if.slave  req_if,
  output logic [3:0]           addr,
  output logic [15:0]          data_in,
  output logic [1:0]           read_Nwrite,
  output logic                 ack_in_read,
  input  logic [15:0]          data_out,
  input  logic                 ack_read,
  input  logic                 ack_write
);

  localparam logic             TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;
  logic             ack_r_s;
  logic             ack_w_s;
  logic             timeout_hit;
  logic [15:0]      enc_addr_full;
  logic [15:0]      enc_wdata;
  dr_dec_t          dec;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_read),
    .q     (ack_r_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_w (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_write),
    .q     (ack_w_s)
  );

  assign enc_addr_full    = dr_encode({6'b000000, req_if.req_addr});
  assign enc_wdata        = dr_encode(req_if.req_wdata);
  assign dec              = dr_decode(data_out);
  assign timeout_hit      = TO_EN && (cnt == TO_LIM);
  assign req_if.req_ready = (state == ST_IDLE);

  // Every rail and handshake output is a flop so the async side never sees glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      err_flag         <= 1'b0;
      addr             <= DR_NULL_ADDR;
      data_in          <= DR_NULL_DATA;
      read_Nwrite      <= DR_NULL_CMD;
      ack_in_read      <= 1'b0;
      req_if.rsp_valid <= 1'b0;
      req_if.rsp_err   <= 1'b0;
      req_if.rsp_rdata <= '0;
    end else begin
      req_if.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_if.req_valid) begin
            cnt      <= '0;
            err_flag <= 1'b0;
            addr     <= enc_addr_full[3:0];
            if (req_if.req_write) begin
              data_in     <= enc_wdata;
              read_Nwrite <= 2'b01;
              state       <= ST_W_REQ;
            end else begin
              data_in     <= DR_NULL_DATA;
              read_Nwrite <= 2'b10;
              state       <= ST_R_REQ;
            end
          end
        end

        ST_W_REQ: begin
          if (ack_w_s || timeout_hit) begin
            err_flag    <= !ack_w_s;
            addr        <= DR_NULL_ADDR;
            data_in     <= DR_NULL_DATA;
            read_Nwrite <= DR_NULL_CMD;
            state       <= ST_W_RTZ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_W_RTZ: begin
          if (!ack_w_s) begin
            req_if.rsp_valid <= 1'b1;
            req_if.rsp_err   <= err_flag;
            state            <= ST_IDLE;
          end
        end

        // A timed-out read skips the capture and releases with zero data.
        ST_R_REQ: begin
          if (ack_r_s) begin
            state <= ST_R_CAP;
          end else if (timeout_hit) begin
            err_flag         <= 1'b1;
            req_if.rsp_rdata <= '0;
            addr             <= DR_NULL_ADDR;
            read_Nwrite      <= DR_NULL_CMD;
            ack_in_read      <= 1'b1;
            state            <= ST_R_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_R_CAP: begin
          req_if.rsp_rdata <= dec.data;
          err_flag         <= err_flag | ~dec.valid;
          addr             <= DR_NULL_ADDR;
          read_Nwrite      <= DR_NULL_CMD;
          ack_in_read      <= 1'b1;
          state            <= ST_R_ACK;
        end

        ST_R_ACK: begin
          if (!ack_r_s) begin
            ack_in_read      <= 1'b0;
            req_if.rsp_valid <= 1'b1;
            req_if.rsp_err   <= err_flag;
            state            <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dr_cache_initiator.sv
// Bench for dr_cache_initiator: a behavioural dual-rail responder plus a word
// array reference model of the cache contents.
module tb_dr_cache_initiator;

  localparam int SYNC = 2;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [1:0]  read_Nwrite;
  logic        ack_in_read;
  logic        ack_read;
  logic        ack_write;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [4];
  logic [7:0] resp_mem [4];

  bit         resp_w_en = 1'b1;
  bit         resp_r_en = 1'b1;
  bit         resp_hold = 1'b0;
  bit         resp_fast = 1'b0;
  logic [7:0] corrupt_mask = '0;
  logic [7:0] corrupt_hi = '0;

  dr_cache_initiator_if bus ();

  dr_cache_initiator #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TMO),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (bus),
    .addr        (addr),
    .data_in     (data_in),
    .read_Nwrite (read_Nwrite),
    .ack_in_read (ack_in_read),
    .data_out    (data_out),
    .ack_read    (ack_read),
    .ack_write   (ack_write)
  );

  always #5 clk = ~clk;

  // Value v on the rails: true rail of pair i carries bit i, false rail its inverse.
  function automatic logic [15:0] rails_of(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = !v[i];
    end
    return r;
  endfunction

  function automatic logic [3:0] addr_rails_of(input logic [1:0] a);
    return {a[1], !a[1], a[0], !a[0]};
  endfunction

  task automatic resp_delay();
    if (!resp_fast) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic resp_timeout(input string what);
    total++;
    bad++;
    $display("[TB] FAIL responder_%s: wait expired, required the initiator to move", what);
  endtask

  // Behavioural asynchronous cache responder following the four-phase protocol.
  initial begin : responder
    logic [1:0]  a;
    logic [7:0]  wv;
    logic [15:0] d;
    int          n;
    ack_read  = 1'b0;
    ack_write = 1'b0;
    data_out  = '0;
    for (int i = 0; i < 4; i++) resp_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (resp_w_en && read_Nwrite == 2'b01 && !ack_write) begin
        resp_delay();
        a = {addr[3], addr[1]};
        for (int i = 0; i < 8; i++) wv[i] = data_in[2*i+1];
        resp_mem[a] = wv;
        ack_write = 1'b1;
        n = 0;
        while (read_Nwrite != 2'b00 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) resp_timeout("w_null");
        resp_delay();
        ack_write = 1'b0;
      end else if (resp_r_en && read_Nwrite == 2'b10 && !ack_read) begin
        resp_delay();
        a = {addr[3], addr[1]};
        d = rails_of(resp_mem[a]);
        for (int i = 0; i < 8; i++)
          if (corrupt_mask[i]) d[2*i +: 2] = corrupt_hi[i] ? 2'b11 : 2'b00;
        data_out = d;
        ack_read = 1'b1;
        n = 0;
        while (!ack_in_read && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) resp_timeout("ack_in_read");
        n = 0;
        while (resp_hold && n < 300) begin @(negedge clk); n++; end
        resp_delay();
        data_out = '0;
        ack_read = 1'b0;
      end
    end
  end

  task automatic run_txn(input bit wr, input logic [1:0] a, input logic [7:0] wd,
                         input bit exp_err, input logic [7:0] exp_rdata,
                         input string tag, output int lat);
    int cyc;
    bit seen, ready_ok, saw_air, air_null_ok;
    cyc = 0;
    while (!bus.req_ready && cyc < 300) begin @(negedge clk); cyc++; end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 2'($urandom);
    bus.req_wdata = 8'($urandom);
    total++;
    if (addr !== addr_rails_of(a)) begin
      bad++; $display("[TB] FAIL %s_addr_rails: got %b want %b", tag, addr, addr_rails_of(a));
    end
    total++;
    if (data_in !== (wr ? rails_of(wd) : 16'h0000)) begin
      bad++; $display("[TB] FAIL %s_data_rails: got %h want %h", tag, data_in, wr ? rails_of(wd) : 16'h0000);
    end
    total++;
    if (read_Nwrite !== (wr ? 2'b01 : 2'b10)) begin
      bad++; $display("[TB] FAIL %s_cmd_rails: got %b want %b", tag, read_Nwrite, wr ? 2'b01 : 2'b10);
    end
    seen = 0; ready_ok = 1; saw_air = 0; air_null_ok = 1; cyc = 0;
    while (!seen && cyc < 400) begin
      if (bus.rsp_valid) seen = 1;
      else begin
        if (bus.req_ready) ready_ok = 0;
        if (ack_in_read) begin
          saw_air = 1;
          if (addr !== 4'b0000 || read_Nwrite !== 2'b00) air_null_ok = 0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    lat = cyc;
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL %s_rsp_timeout: no rsp_valid in %0d cycles", tag, cyc);
      return;
    end
    total++;
    if (!ready_ok) begin bad++; $display("[TB] FAIL %s_ready_busy: req_ready=1 while busy, want 0", tag); end
    total++;
    if (bus.rsp_err !== exp_err) begin
      bad++; $display("[TB] FAIL %s_rsp_err: got %b want %b", tag, bus.rsp_err, exp_err);
    end
    total++;
    if ({addr, data_in, read_Nwrite, ack_in_read} !== 23'd0) begin
      bad++; $display("[TB] FAIL %s_null_at_rsp: got %b_%h_%b_%b want all zero", tag, addr, data_in, read_Nwrite, ack_in_read);
    end
    total++;
    if (saw_air !== !wr || !air_null_ok) begin
      bad++; $display("[TB] FAIL %s_ack_in_read: seen=%b null_ok=%b want seen=%b null_ok=1", tag, saw_air, air_null_ok, !wr);
    end
    if (!wr) begin
      total++;
      if (bus.rsp_rdata !== exp_rdata) begin
        bad++; $display("[TB] FAIL %s_rsp_rdata: got %h want %h", tag, bus.rsp_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({addr, data_in, read_Nwrite, ack_in_read, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 33'd0) begin
      bad++; $display("[TB] FAIL reset_outputs: got %b_%h_%b_%b_%b_%b_%h want zero", addr, data_in,
                      read_Nwrite, ack_in_read, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int lat;
    resp_fast = 1'b1;
    run_txn(1'b1, 2'd2, 8'hA5, 1'b0, 8'h00, "write", lat);
    ref_mem[2] = 8'hA5;
    resp_fast = 1'b0;
  endtask

  task automatic test_read();
    int lat;
    resp_mem[1] = 8'h3C;
    ref_mem[1]  = 8'h3C;
    run_txn(1'b0, 2'd1, 8'h00, 1'b0, 8'h3C, "read", lat);
  endtask

  task automatic test_bad_pair();
    int lat;
    corrupt_mask = 8'h01;
    corrupt_hi   = 8'h01;
    run_txn(1'b0, 2'd2, 8'h00, 1'b1, ref_mem[2] & 8'hFE, "bad_pair", lat);
    corrupt_mask = 8'h00;
  endtask

  task automatic test_timeout();
    int lat;
    resp_w_en = 1'b0;
    run_txn(1'b1, 2'd0, 8'h77, 1'b1, 8'h00, "timeout", lat);
    resp_w_en = 1'b1;
    total++;
    if (lat < TMO || lat > TMO + SYNC + 4) begin
      bad++; $display("[TB] FAIL timeout_latency: got %0d cycles want %0d..%0d", lat, TMO, TMO + SYNC + 4);
    end
  endtask

  task automatic test_reset_mid();
    int n, lat;
    bit rsp_seen;
    resp_hold = 1'b1;
    resp_mem[3] = 8'h5E;
    ref_mem[3]  = 8'h5E;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 2'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!ack_in_read && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!ack_in_read) begin bad++; $display("[TB] FAIL rst_mid_reach_ack: ack_in_read=0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({addr, data_in, read_Nwrite, ack_in_read} !== 23'd0) begin
      bad++; $display("[TB] FAIL rst_mid_async: got %b_%h_%b_%b want all zero", addr, data_in, read_Nwrite, ack_in_read);
    end
    resp_hold = 1'b0;
    rsp_seen = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid) rsp_seen = 1; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (bus.rsp_valid) rsp_seen = 1; end
    total++;
    if (rsp_seen) begin bad++; $display("[TB] FAIL rst_mid_no_rsp: rsp_valid=1 want 0"); end
    run_txn(1'b0, 2'd3, 8'h00, 1'b0, 8'h5E, "after_rst", lat);
  endtask

  task automatic test_stray_ack();
    bit ok;
    resp_w_en = 1'b0; resp_r_en = 1'b0;
    @(negedge clk);
    ack_write = 1'b1; ack_read = 1'b1;
    ok = 1;
    repeat (6) begin
      @(negedge clk);
      if (!bus.req_ready || bus.rsp_valid || ack_in_read || read_Nwrite != 2'b00) ok = 0;
    end
    ack_write = 1'b0; ack_read = 1'b0;
    repeat (4) @(negedge clk);
    resp_w_en = 1'b1; resp_r_en = 1'b1;
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL stray_ack: initiator reacted in idle, want no reaction"); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_txn(1'b1, 2'd3, 8'hFF, 1'b0, 8'h00, "b2b_wr", lat);
    ref_mem[3] = 8'hFF;
    run_txn(1'b0, 2'd3, 8'h00, 1'b0, 8'hFF, "b2b_rd", lat);
  endtask

  task automatic test_random();
    int lat;
    logic [1:0] a;
    logic [7:0] wd;
    for (int k = 0; k < 24; k++) begin
      a  = 2'($urandom);
      wd = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        run_txn(1'b1, a, wd, 1'b0, 8'h00, "rnd_wr", lat);
        ref_mem[a] = wd;
      end else begin
        corrupt_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        corrupt_hi   = 8'($urandom);
        run_txn(1'b0, a, 8'h00, corrupt_mask != 8'h00, ref_mem[a] & ~corrupt_mask, "rnd_rd", lat);
        corrupt_mask = 8'h00;
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_bad_pair();
    test_timeout();
    test_reset_mid();
    test_stray_ack();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
